// File: rtl/control_sequencer.sv
// control_sequencer: four-state instruction sequencer (IDLE -> DECODE -> EXEC)
// that turns 3-bit opcodes into one-cycle, registered datapath control pulses.
// Each instruction takes three cycles. HALT parks the FSM until reset.
module control_sequencer (
    input  logic       MainClock,
    input  logic       MainReset,
    input  logic [2:0] InstrIn,
    input  logic       InstrValid,
    output logic       Ready,
    output logic       LatchA,
    output logic       LatchB,
    output logic       EnableIn,
    output logic       EnableA,
    output logic       EnableAlu,
    output logic       AddSub,
    output logic       EnableOut,
    output logic       Halted,
    output logic [7:0] InstrCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDA  = 3'b001,
        OP_LDB  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_OUTA = 3'b101,
        OP_ADDO = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef struct packed {
        logic latch_a;
        logic latch_b;
        logic en_in;
        logic en_a;
        logic en_alu;
        logic add_sub;
        logic en_out;
    } ctrl_t;

    state_t     r_state;
    state_t     w_state_next;
    opcode_t    r_instr;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_next;
    logic [7:0] r_count;
    logic       w_accept;
    logic       w_retire;

    // Next-state logic; control values are decoded in DECODE so that the
    // registered outputs are valid for exactly the EXEC cycle.
    always_comb begin
        w_state_next = r_state;
        w_ctrl_next  = '0;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (InstrValid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = ST_EXEC;
                case (r_instr)
                    OP_LDA: begin
                        w_ctrl_next.en_in   = 1'b1;
                        w_ctrl_next.latch_a = 1'b1;
                    end
                    OP_LDB: begin
                        w_ctrl_next.en_in   = 1'b1;
                        w_ctrl_next.latch_b = 1'b1;
                    end
                    OP_ADD: begin
                        w_ctrl_next.en_alu  = 1'b1;
                        w_ctrl_next.latch_a = 1'b1;
                    end
                    OP_SUB: begin
                        w_ctrl_next.en_alu  = 1'b1;
                        w_ctrl_next.latch_a = 1'b1;
                        w_ctrl_next.add_sub = 1'b1;
                    end
                    OP_OUTA: begin
                        w_ctrl_next.en_a   = 1'b1;
                        w_ctrl_next.en_out = 1'b1;
                    end
                    OP_ADDO: begin
                        w_ctrl_next.en_alu = 1'b1;
                        w_ctrl_next.en_out = 1'b1;
                    end
                    default: w_ctrl_next = '0;
                endcase
            end
            ST_EXEC: begin
                w_retire     = (r_instr != OP_HALT);
                w_state_next = (r_instr == OP_HALT) ? ST_HALT : ST_IDLE;
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    // Instruction register, loaded only on acceptance so InstrIn is ignored while busy.
    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset)     r_instr <= OP_NOP;
        else if (w_accept) r_instr <= opcode_t'(InstrIn);
    end

    // Registered control outputs for glitch-free datapath enables.
    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) r_ctrl <= '0;
        else           r_ctrl <= w_ctrl_next;
    end

    // Executed-instruction counter, bumped when leaving EXEC (wraps naturally).
    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset)     r_count <= '0;
        else if (w_retire) r_count <= r_count + 8'd1;
    end

    assign Ready      = (r_state == ST_IDLE);
    assign Halted     = (r_state == ST_HALT);
    assign LatchA     = r_ctrl.latch_a;
    assign LatchB     = r_ctrl.latch_b;
    assign EnableIn   = r_ctrl.en_in;
    assign EnableA    = r_ctrl.en_a;
    assign EnableAlu  = r_ctrl.en_alu;
    assign AddSub     = r_ctrl.add_sub;
    assign EnableOut  = r_ctrl.en_out;
    assign InstrCount = r_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the expected EXEC
// control vector and post-instruction count; a negedge monitor pops and compares.
module tb_control_sequencer;

    logic       clk;
    logic       MainReset;
    logic [2:0] InstrIn;
    logic       InstrValid;
    logic       Ready;
    logic       LatchA;
    logic       LatchB;
    logic       EnableIn;
    logic       EnableA;
    logic       EnableAlu;
    logic       AddSub;
    logic       EnableOut;
    logic       Halted;
    logic [7:0] InstrCount;
    logic [6:0] act_ctrl;

    typedef struct {
        logic [6:0] ctrl;
        logic [7:0] count;
        logic       halted;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       cur;
    int         errors = 0;
    int         checks = 0;
    int         phase  = 0;
    logic [7:0] m_count;

    control_sequencer dut (
        .MainClock  (clk),
        .MainReset  (MainReset),
        .InstrIn    (InstrIn),
        .InstrValid (InstrValid),
        .Ready      (Ready),
        .LatchA     (LatchA),
        .LatchB     (LatchB),
        .EnableIn   (EnableIn),
        .EnableA    (EnableA),
        .EnableAlu  (EnableAlu),
        .AddSub     (AddSub),
        .EnableOut  (EnableOut),
        .Halted     (Halted),
        .InstrCount (InstrCount)
    );

    assign act_ctrl = {LatchA, LatchB, EnableIn, EnableA, EnableAlu, AddSub, EnableOut};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected EXEC outputs {LatchA,LatchB,EnableIn,EnableA,EnableAlu,AddSub,EnableOut}.
    function automatic logic [6:0] ctrl_of(input logic [2:0] op);
        case (op)
            3'b001:  return 7'b1010000; // LDA
            3'b010:  return 7'b0110000; // LDB
            3'b011:  return 7'b1000100; // ADD
            3'b100:  return 7'b1000110; // SUB
            3'b101:  return 7'b0001001; // OUTA
            3'b110:  return 7'b0000101; // ADDO
            default: return 7'b0000000; // NOP, HALT
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: detects acceptance from the handshake, then checks DECODE, EXEC and retire cycles.
    always @(negedge clk) begin
        if (MainReset) begin
            phase = 0;
            sb_q.delete();
        end else begin
            check("bus_single_driver", ((int'(EnableIn) + int'(EnableA) + int'(EnableAlu)) <= 1) ? 1 : 0, 1);
            if (phase == 2) begin
                check("exec_ready", Ready, 0);
                if (sb_q.size() == 0) begin
                    check("sb_empty", 0, 1);
                    phase = 0;
                end else begin
                    cur = sb_q.pop_front();
                    check("exec_ctrl", act_ctrl, cur.ctrl);
                    phase = 3;
                end
            end else begin
                check("quiet_ctrl", act_ctrl, 0);
                if (phase == 3) begin
                    check("count", InstrCount, cur.count);
                    check("halted", Halted, cur.halted);
                    phase = 0;
                end
                if (phase == 1) begin
                    check("decode_ready", Ready, 0);
                    phase = 2;
                end else if (phase == 0 && Ready && InstrValid) begin
                    phase = 1;
                end
            end
        end
    end

    // Present an opcode, wait (bounded) for Ready, push the expectation, let the edge accept it.
    task automatic issue(input logic [2:0] op, input bit hold, output int waited);
        exp_t e;
        InstrIn    = op;
        InstrValid = 1'b1;
        waited     = 0;
        @(negedge clk);
        while (!Ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!Ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            if (op != 3'b111) m_count = m_count + 8'd1;
            e.ctrl   = ctrl_of(op);
            e.count  = m_count;
            e.halted = (op == 3'b111);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) InstrValid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        MainReset  = 1'b1;
        InstrValid = 1'b0;
        InstrIn    = 3'b000;
        m_count    = 8'd0;
        #1;
        check("rst_ready", Ready, 1);
        check("rst_halted", Halted, 0);
        check("rst_count", InstrCount, 0);
        check("rst_ctrl", act_ctrl, 0);
        @(posedge clk);
        #1;
        MainReset = 1'b0;
    endtask

    task automatic drain();
        InstrValid = 1'b0;
        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        int w;
        MainReset  = 1'b1;
        InstrValid = 1'b0;
        InstrIn    = 3'b000;
        m_count    = 8'd0;

        // Single LDA after reset.
        do_reset();
        issue(3'b001, 1'b0, w);
        check("first_accept_wait", w, 0);
        drain();
        check("lda_count", InstrCount, 1);

        // Back-to-back SUB with InstrValid held high: one accept every 3 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(3'b100, 1'b1, w);
            if (i > 0) check("b2b_gap", w, 2);
        end
        drain();
        check("sub_count", InstrCount, 4);

        // All eight opcodes, HALT last.
        do_reset();
        for (int op = 0; op < 8; op++) begin
            issue(3'(op), 1'b0, w);
        end
        drain();
        InstrIn    = 3'b001;
        InstrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_ready", Ready, 0);
            check("halt_flag", Halted, 1);
            check("halt_count", InstrCount, 7);
        end
        InstrValid = 1'b0;

        // Counter wrap: 255 NOPs then ADDO.
        do_reset();
        for (int i = 0; i < 255; i++) issue(3'b000, 1'b1, w);
        check("pre_wrap_ready", 1, 1);
        issue(3'b110, 1'b0, w);
        drain();
        check("wrap_count", InstrCount, 0);

        // Reset mid-EXEC of OUTA, between clock edges.
        do_reset();
        issue(3'b101, 1'b0, w);
        @(posedge clk);
        #2;
        check("outa_en_a", EnableA, 1);
        check("outa_en_out", EnableOut, 1);
        MainReset = 1'b1;
        m_count   = 8'd0;
        #1;
        check("abort_en_a", EnableA, 0);
        check("abort_en_out", EnableOut, 0);
        check("abort_ready", Ready, 1);
        check("abort_count", InstrCount, 0);
        check("abort_halted", Halted, 0);
        @(posedge clk);
        #1;
        MainReset = 1'b0;
        issue(3'b001, 1'b0, w);
        check("post_abort_accept_wait", w, 0);
        drain();

        // InstrIn changes from ADD to SUB during DECODE; ADD must still execute.
        do_reset();
        issue(3'b011, 1'b0, w);
        InstrIn = 3'b100;
        drain();
        check("add_kept_count", InstrCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 MainClock  input  1  system clock; all state updates on rising edge.
REQ-003 MainReset  input  1  asynchronous, active-high reset.
REQ-004 InstrIn  input  3  opcode: 000 NOP, 001 LDA, 010 LDB, 011 ADD, 100 SUB, 101 OUTA, 110 ADDO, 111 HALT.
REQ-005 InstrValid  input  1  InstrIn valid this cycle.
REQ-006 Ready  output  1  sequencer accepts an instruction this cycle.
REQ-007 LatchA, LatchB  output  1 each  load register A / register B at the next clock.
REQ-008 EnableIn, EnableA, EnableAlu  output  1 each  drive internal bus from input port / register A / ALU.
REQ-009 AddSub  output  1  ALU mode: 0 add, 1 subtract.
REQ-010 EnableOut  output  1  load output register from internal bus.
REQ-011 Halted  output  1  HALT executed; no further instructions accepted.
REQ-012 InstrCount  output  8  count of executed non-HALT instructions.

Function
REQ-013 The FSM SHALL have states IDLE, DECODE, EXEC, HALT.
REQ-014 IDLE: Ready=1; on InstrValid=1, capture InstrIn into a 3-bit instruction register and go to DECODE; otherwise remain in IDLE.
REQ-015 DECODE: Ready=0; all control outputs 0; go to EXEC next cycle.
REQ-016 EXEC: Ready=0; control outputs per REQ-017 for exactly one cycle; then IDLE, or HALT if opcode 111.
REQ-017 Control outputs during EXEC (all unlisted outputs 0): LDA EnableIn+LatchA; LDB EnableIn+LatchB; ADD EnableAlu+LatchA, AddSub=0; SUB EnableAlu+LatchA, AddSub=1; OUTA EnableA+EnableOut; ADDO EnableAlu+EnableOut, AddSub=0; NOP and HALT none.
REQ-018 Control outputs SHALL be registered (glitch-free) and SHALL be 0 in IDLE, DECODE and HALT.
REQ-019 At most one of EnableIn, EnableA, EnableAlu SHALL be 1 in any cycle (single bus driver).
REQ-020 AddSub SHALL be stable for the whole EXEC cycle and 0 outside EXEC.
REQ-021 Latency: an instruction accepted at edge N has its control outputs asserted in the cycle after edge N+1, deasserted at edge N+2; Ready returns to 1 after edge N+2. Throughput is 1 instruction per 3 cycles.
REQ-022 InstrValid while Ready=0 SHALL be ignored; the upstream source holds the instruction until Ready=1.
REQ-023 InstrCount SHALL increment by 1 at the edge that leaves EXEC for every opcode except 111, and SHALL wrap 255 -> 0.
REQ-024 HALT: Halted=1, Ready=0, control outputs 0; exited only by reset.
REQ-025 An InstrIn change during DECODE/EXEC SHALL NOT affect the instruction executing.

Reset
REQ-026 MainReset=1 SHALL immediately, without a clock edge, force: state IDLE, instruction register 000, all control outputs 0, AddSub 0, Halted 0, InstrCount 0, Ready 1.
REQ-027 Reset asserted during DECODE or EXEC SHALL abort the instruction: no further control pulse and no count increment.
REQ-028 After MainReset deasserts, the first instruction SHALL be accepted at the first rising edge with InstrValid=1.

Verification
REQ-029 Reset, then LDA (001) with InstrValid for 1 cycle -> EnableIn=LatchA=1 for exactly one cycle, 2 cycles after accept; InstrCount=1.
REQ-030 Back-to-back SUB (100) with InstrValid held high -> accepts every 3rd cycle; each EXEC shows EnableAlu=LatchA=AddSub=1; after 4 accepts InstrCount=4.
REQ-031 All 8 opcodes in sequence, HALT last -> per-cycle outputs match REQ-017; bus-driver one-hot checked every cycle; after HALT Halted=1, Ready=0, InstrCount=7, further InstrValid ignored.
REQ-032 Preload InstrCount to 255 via 255 NOPs, then one ADDO (110) -> InstrCount wraps to 0; EnableAlu=EnableOut=1, AddSub=0 during EXEC.
REQ-033 Assert MainReset mid-EXEC of OUTA (101), between clock edges -> EnableA/EnableOut drop to 0 immediately; InstrCount unchanged at 0; Ready=1.
REQ-034 Change InstrIn from 011 to 100 during DECODE -> EXEC still shows AddSub=0 (ADD executed).
